// File: rtl/addatone_pkg.sv
// Shared types and constants for the additive-synthesis sample scheduler.
// Holds the scheduler FSM state enum, accumulator width and Nyquist limit.
package addatone_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    READ,
    LOOKUP,
    ACCUM,
    OUTPUT
  } sched_state_t;

  localparam int          ACC_W   = 34;
  localparam logic [16:0] NYQUIST = 17'h08000;

endpackage

// File: rtl/harmonic_scheduler_sample_timer.sv
// Sample-period counter: counts 0..SAMPLE_INTERVAL-1 and wraps.
// Ports: i_Clock, i_Reset_n, i_Clear (sync restart), o_Tick (1 clk at wrap).
module sample_timer #(
  parameter int SAMPLE_INTERVAL = 1000
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int CW = $clog2(SAMPLE_INTERVAL);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_INTERVAL - 1);

  logic [CW-1:0] count;

  assign o_Tick = (count == LAST);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count <= '0;
    end else if (i_Clear || o_Tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/harmonic_scheduler.sv
// Walks harmonics once per sample period: phase RAM -> sine LUT -> scale -> sum.
// Ports: config (i_Frequency..i_Comb_Interval), position RAM (o_Pos_*, i_Pos_Rdata),
//   sine LUT (o_LUT_Addr, i_LUT_Data), sample valid/ready out, status flags.
// Build option: HARMONIC_SCHED_SATURATE_EN clamps the output instead of wrapping.
module harmonic_scheduler
  import addatone_pkg::*;
#(
  parameter int SAMPLE_INTERVAL = 1000,
  parameter int MAX_HARMONICS   = 200,
  parameter int HARM_W          = 8,
  parameter int DIV_BIT         = 9,
  parameter int LUT_ADDR_W      = 11,
  parameter int OUT_SHIFT       = 4
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic [15:0]           i_Frequency,
  input  logic [15:0]           i_Freq_Scale,
  input  logic [DIV_BIT-1:0]    i_Harmonic_Scale,
  input  logic [DIV_BIT-1:0]    i_Scale_Initial,
  input  logic [7:0]            i_Comb_Interval,
  output logic [HARM_W-1:0]     o_Pos_Addr,
  output logic                  o_Pos_Wr,
  output logic [15:0]           o_Pos_Wdata,
  input  logic [15:0]           i_Pos_Rdata,
  output logic [LUT_ADDR_W-1:0] o_LUT_Addr,
  input  logic [15:0]           i_LUT_Data,
  output logic [15:0]           o_Sample_Value,
  output logic                  o_Sample_Valid,
  input  logic                  i_Sample_Ready,
  output logic                  o_Freq_Too_High,
  output logic                  o_Overrun,
  output logic                  o_Busy
);

  localparam int PW = 17 + DIV_BIT;
  localparam int SH = DIV_BIT + OUT_SHIFT;
  localparam logic [HARM_W-1:0] H_LAST = HARM_W'(MAX_HARMONICS - 1);

  sched_state_t state, state_nxt;

  logic                     init_go;
  logic [HARM_W-1:0]        init_cnt;
  logic [HARM_W-1:0]        h;
  logic [16:0]              inc;
  logic [DIV_BIT-1:0]       scale;
  logic [7:0]               comb_cnt;
  logic signed [ACC_W-1:0]  acc;

  logic [15:0]              freq_q;
  logic [15:0]              fscale_q;
  logic [DIV_BIT-1:0]       hscale_q;
  logic [7:0]               comb_q;

  logic                     tick;
  logic                     start;
  logic                     timer_clr;
  logic [15:0]              pos;
  logic                     muted;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic [2*DIV_BIT-1:0]     sprod;
  logic [DIV_BIT-1:0]       scale_nxt;
  logic [17:0]              inc_sum;
  logic [7:0]               comb_nxt;
  logic                     nyq;
  logic                     stop;
  logic signed [ACC_W-1:0]  acc_sh;
  logic [15:0]              sample_out;

  sample_timer #(
    .SAMPLE_INTERVAL(SAMPLE_INTERVAL)
  ) u_timer (
    .i_Clock  (i_Clock),
    .i_Reset_n(i_Reset_n),
    .i_Clear  (timer_clr),
    .o_Tick   (tick)
  );

  // A pending unaccepted sample blocks a new start; that tick is dropped.
  assign start     = tick && (state == IDLE) && !o_Sample_Valid;
  assign timer_clr = (state == INIT) && (state_nxt == IDLE);
  assign o_Busy    = init_go && (state != IDLE);

  assign pos = i_Pos_Rdata + inc[15:0];

  // Harmonic index 0 is the fundamental and is never muted.
  assign muted = (comb_cnt == 8'd1) && (h != '0);

  assign prod = $signed({{(PW-16){i_LUT_Data[15]}}, i_LUT_Data})
              * $signed({{(PW-DIV_BIT){1'b0}}, scale});

  assign acc_nxt = muted ? acc
                 : acc + {{(ACC_W-PW){prod[PW-1]}}, prod};

  assign sprod     = {{DIV_BIT{1'b0}}, scale} * {{DIV_BIT{1'b0}}, hscale_q};
  assign scale_nxt = DIV_BIT'(sprod >> DIV_BIT);

  assign inc_sum = {1'b0, inc} + {2'b00, freq_q} + {2'b00, fscale_q};
  assign nyq     = (inc_sum >= {1'b0, NYQUIST});

  always_comb begin
    comb_nxt = comb_cnt;
    if (comb_q != 8'd0) begin
      comb_nxt = (comb_cnt == 8'd1) ? comb_q : comb_cnt - 8'd1;
    end
  end

  assign stop = (h == H_LAST) || (scale_nxt == '0) || nyq;

  assign acc_sh = acc >>> SH;

`ifdef HARMONIC_SCHED_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(32'sd32768);
  always_comb begin
    sample_out = 16'(acc_sh);
    if (acc_sh > SAT_HI) begin
      sample_out = 16'h7FFF;
    end else if (acc_sh < SAT_LO) begin
      sample_out = 16'h8000;
    end
  end
`else
  assign sample_out = 16'(acc_sh);
`endif

  always_comb begin
    state_nxt   = state;
    o_Pos_Addr  = '0;
    o_Pos_Wr    = 1'b0;
    o_Pos_Wdata = '0;
    o_LUT_Addr  = '0;
    unique case (state)
      INIT: begin
        o_Pos_Addr = init_cnt;
        o_Pos_Wr   = init_go;
        if (init_go && (init_cnt == H_LAST)) state_nxt = IDLE;
      end
      IDLE: begin
        if (start) state_nxt = READ;
      end
      READ: begin
        o_Pos_Addr = h;
        state_nxt  = LOOKUP;
      end
      LOOKUP: begin
        o_Pos_Addr  = h;
        o_Pos_Wr    = 1'b1;
        o_Pos_Wdata = pos;
        o_LUT_Addr  = pos[15 -: LUT_ADDR_W];
        state_nxt   = ACCUM;
      end
      ACCUM: begin
        state_nxt = stop ? OUTPUT : READ;
      end
      OUTPUT: begin
        state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      init_go         <= 1'b0;
      init_cnt        <= '0;
      h               <= '0;
      inc             <= '0;
      scale           <= '0;
      comb_cnt        <= '0;
      acc             <= '0;
      freq_q          <= '0;
      fscale_q        <= '0;
      hscale_q        <= '0;
      comb_q          <= '0;
      o_Sample_Value  <= '0;
      o_Sample_Valid  <= 1'b0;
      o_Freq_Too_High <= 1'b0;
      o_Overrun       <= 1'b0;
    end else begin
      o_Overrun <= tick && !start;
      if (o_Sample_Valid && i_Sample_Ready) begin
        o_Sample_Valid <= 1'b0;
      end
      unique case (state)
        INIT: begin
          init_go <= 1'b1;
          if (init_go) init_cnt <= init_cnt + 1'b1;
        end
        IDLE: begin
          if (start) begin
            freq_q   <= i_Frequency;
            fscale_q <= i_Freq_Scale;
            hscale_q <= i_Harmonic_Scale;
            comb_q   <= i_Comb_Interval;
            acc      <= '0;
            h        <= '0;
            inc      <= {1'b0, i_Frequency};
            scale    <= i_Scale_Initial;
            comb_cnt <= i_Comb_Interval;
          end
        end
        ACCUM: begin
          acc      <= acc_nxt;
          scale    <= scale_nxt;
          inc      <= 17'(inc_sum);
          comb_cnt <= comb_nxt;
          h        <= h + 1'b1;
          if (stop) o_Freq_Too_High <= nyq;
        end
        OUTPUT: begin
          o_Sample_Value <= sample_out;
          o_Sample_Valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_harmonic_scheduler.sv
// Directed bench for harmonic_scheduler with behavioural position RAM and LUT.
// Table of per-sample vectors plus hand sequences for init, backpressure, reset.
module tb_harmonic_scheduler;

  logic        i_Clock = 1'b0;
  logic        i_Reset_n = 1'b0;
  logic [15:0] i_Frequency = '0;
  logic [15:0] i_Freq_Scale = '0;
  logic [8:0]  i_Harmonic_Scale = '0;
  logic [8:0]  i_Scale_Initial = '0;
  logic [7:0]  i_Comb_Interval = '0;
  logic [7:0]  o_Pos_Addr;
  logic        o_Pos_Wr;
  logic [15:0] o_Pos_Wdata;
  logic [15:0] i_Pos_Rdata = '0;
  logic [10:0] o_LUT_Addr;
  logic [15:0] i_LUT_Data = '0;
  logic [15:0] o_Sample_Value;
  logic        o_Sample_Valid;
  logic        i_Sample_Ready = 1'b1;
  logic        o_Freq_Too_High;
  logic        o_Overrun;
  logic        o_Busy;

  logic [15:0] lut_val = '0;
  logic [15:0] ram [0:255];

  int n_chk  = 0;
  int n_fail = 0;

  harmonic_scheduler dut (
    .i_Clock         (i_Clock),
    .i_Reset_n       (i_Reset_n),
    .i_Frequency     (i_Frequency),
    .i_Freq_Scale    (i_Freq_Scale),
    .i_Harmonic_Scale(i_Harmonic_Scale),
    .i_Scale_Initial (i_Scale_Initial),
    .i_Comb_Interval (i_Comb_Interval),
    .o_Pos_Addr      (o_Pos_Addr),
    .o_Pos_Wr        (o_Pos_Wr),
    .o_Pos_Wdata     (o_Pos_Wdata),
    .i_Pos_Rdata     (i_Pos_Rdata),
    .o_LUT_Addr      (o_LUT_Addr),
    .i_LUT_Data      (i_LUT_Data),
    .o_Sample_Value  (o_Sample_Value),
    .o_Sample_Valid  (o_Sample_Valid),
    .i_Sample_Ready  (i_Sample_Ready),
    .o_Freq_Too_High (o_Freq_Too_High),
    .o_Overrun       (o_Overrun),
    .o_Busy          (o_Busy)
  );

  always #5 i_Clock = ~i_Clock;

  always @(posedge i_Clock) begin
    if (o_Pos_Wr) ram[o_Pos_Addr] <= o_Pos_Wdata;
    i_Pos_Rdata <= ram[o_Pos_Addr];
    i_LUT_Data  <= lut_val;
  end

  typedef struct {
    logic [15:0] freq;
    logic [15:0] fscale;
    logic [8:0]  hs;
    logic [8:0]  si;
    logic [7:0]  comb;
    logic [15:0] lut;
    logic [15:0] exp_val;
    logic        exp_fth;
    int          exp_n;
    logic [15:0] exp_w0;
    logic [10:0] exp_la0;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  task automatic apply_cfg(input vec_t v);
    i_Frequency      = v.freq;
    i_Freq_Scale     = v.fscale;
    i_Harmonic_Scale = v.hs;
    i_Scale_Initial  = v.si;
    i_Comb_Interval  = v.comb;
    lut_val          = v.lut;
  endtask

  task automatic wait_busy(output bit ok);
    int c;
    c = 0;
    while (!o_Busy && c < 1500) begin
      @(negedge i_Clock);
      c++;
    end
    ok = o_Busy;
  endtask

  task automatic run_vec(input int k);
    vec_t        v;
    int          cyc;
    int          nw;
    bit          seen;
    bit          ok;
    logic [15:0] w0;
    logic [10:0] la0;
    v = vecs[k];
    apply_cfg(v);
    wait_busy(ok);
    if (!ok) begin
      timeout($sformatf("v%0d start", k));
      return;
    end
    cyc = 0; nw = 0; seen = 0; w0 = '0; la0 = '0;
    while (!o_Sample_Valid && cyc < 1000) begin
      if (o_Pos_Wr) begin
        if (!seen) begin
          w0   = o_Pos_Wdata;
          la0  = o_LUT_Addr;
          seen = 1;
        end
        nw++;
      end
      @(negedge i_Clock);
      cyc++;
    end
    if (!o_Sample_Valid) begin
      timeout($sformatf("v%0d valid", k));
      return;
    end
    check($sformatf("v%0d value", k), 32'(o_Sample_Value), 32'(v.exp_val));
    check($sformatf("v%0d freq_too_high", k), 32'(o_Freq_Too_High), 32'(v.exp_fth));
    check($sformatf("v%0d harmonics", k), 32'(nw), 32'(v.exp_n));
    check($sformatf("v%0d latency", k), 32'(cyc), 32'(3 * v.exp_n + 1));
    check($sformatf("v%0d pos0 write", k), 32'(w0), 32'(v.exp_w0));
    check($sformatf("v%0d lut addr0", k), 32'(la0), 32'(v.exp_la0));
    @(negedge i_Clock);
  endtask

  initial begin
    int   nw;
    bit   seq_ok;
    bit   ok;
    bit   held;
    int   novr;
    int   last;
    int   c;
    logic [15:0] vref;

    foreach (ram[i]) ram[i] = 16'hDEAD;

    vecs[0] = '{16'd90,   16'd0,      9'd0,   9'd511, 8'd0, 16'h4000,
                16'd1022, 1'b0, 1,   16'h005A, 11'h002};
    vecs[1] = '{16'h3000, 16'd0,      9'd511, 9'd511, 8'd0, 16'h4000,
                16'd2042, 1'b1, 2,   16'h305A, 11'h182};
    vecs[2] = '{16'h1000, 16'd0,      9'd511, 9'd511, 8'd3, 16'h4000,
                16'd5082, 1'b1, 7,   16'h405A, 11'h202};
    vecs[3] = '{16'h0100, 16'd0,      9'd256, 9'd256, 8'd0, 16'hC000,
                16'hFC02, 1'b0, 9,   16'h415A, 11'h20A};
    vecs[4] = '{16'h1000, 16'h1000,   9'd511, 9'd100, 8'd0, 16'h2000,
                16'd394,  1'b1, 4,   16'h515A, 11'h28A};
`ifdef HARMONIC_SCHED_SATURATE_EN
    vecs[5] = '{16'd1,    16'd0,      9'd511, 9'd511, 8'd0, 16'h7FFF,
                16'h7FFF, 1'b0, 200, 16'h515B, 11'h28A};
`else
    vecs[5] = '{16'd1,    16'd0,      9'd511, 9'd511, 8'd0, 16'h7FFF,
                16'd1509, 1'b0, 200, 16'h515B, 11'h28A};
`endif

    repeat (3) @(negedge i_Clock);
    check("reset wr", 32'(o_Pos_Wr), 32'd0);
    check("reset busy", 32'(o_Busy), 32'd0);
    check("reset valid", 32'(o_Sample_Valid), 32'd0);
    check("reset value", 32'(o_Sample_Value), 32'd0);
    check("reset overrun", 32'(o_Overrun), 32'd0);
    check("reset fth", 32'(o_Freq_Too_High), 32'd0);

    i_Reset_n = 1'b1;
    nw = 0; seq_ok = 1; c = 0;
    @(negedge i_Clock);
    while (o_Busy && c < 400) begin
      if (o_Pos_Wr) begin
        if (o_Pos_Addr != 8'(nw) || o_Pos_Wdata != 16'd0) seq_ok = 0;
        nw++;
      end
      @(negedge i_Clock);
      c++;
    end
    check("init writes", 32'(nw), 32'd200);
    check("init sequence", 32'(seq_ok), 32'd1);
    check("init busy done", 32'(o_Busy), 32'd0);

    for (int k = 0; k < 6; k++) run_vec(k);

    i_Sample_Ready = 1'b0;
    apply_cfg(vecs[0]);
    wait_busy(ok);
    c = 0;
    while (!o_Sample_Valid && c < 100) begin
      @(negedge i_Clock);
      c++;
    end
    if (!o_Sample_Valid) begin
      timeout("backpressure valid");
    end else begin
      vref = o_Sample_Value;
      check("bp value", 32'(vref), 32'd1022);
      held = 1; novr = 0; last = 0;
      for (int i = 1; i <= 2500; i++) begin
        @(negedge i_Clock);
        if (!o_Sample_Valid || o_Sample_Value !== vref) held = 0;
        if (o_Overrun) begin
          novr++;
          last = i;
        end
      end
      check("bp held", 32'(held), 32'd1);
      check("bp overruns", 32'(novr), 32'd2);
      if (novr == 2) begin
        repeat (last + 999 - 2500) @(negedge i_Clock);
        i_Sample_Ready = 1'b1;
        @(negedge i_Clock);
        check("same-cycle overrun", 32'(o_Overrun), 32'd1);
        check("same-cycle accepted", 32'(o_Sample_Valid), 32'd0);
        check("same-cycle no start", 32'(o_Busy), 32'd0);
      end
    end
    i_Sample_Ready = 1'b1;

    wait_busy(ok);
    if (!ok) begin
      timeout("abort start");
    end else begin
      repeat (2) @(negedge i_Clock);
      i_Reset_n = 1'b0;
      #1;
      check("abort busy", 32'(o_Busy), 32'd0);
      check("abort wr", 32'(o_Pos_Wr), 32'd0);
      check("abort valid", 32'(o_Sample_Valid), 32'd0);
      @(negedge i_Clock);
      i_Reset_n = 1'b1;
      repeat (3) @(negedge i_Clock);
      check("abort reinit", 32'(o_Pos_Wr), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
